intercon_wb_decoder: RTL and testbench

//  Registered 1-master/N-slave Wishbone classic interconnect; successor to the combinational decoder.

---
 rtl/intercon_wb_decoder.sv | 151 +++++++++++++++
 tb/tb_intercon_wb_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/intercon_wb_decoder.sv
// intercon_wb_decoder
//   Registered Wishbone classic interconnect, one master to WB_NUM_SLAVES slaves.
//   The slave index is latched when a request is decoded. Only that slave's
//   ack/err/data reach the master. Further features:
//     - an unmapped index gives a one-cycle error;
//     - a stalled slave gives a timeout error;
//     - a slave err is passed on to the master.
// Ports
//   clk_i, rst_ni               clock, async active-low reset
//   master_{dat,we,sel,adr,cyc,stb}_i   master request
//   master_{dat,ack,err}_o              master response
//   slave_{dat,sel,adr}_o               broadcast copies of the master request
//   slave_{we,cyc,stb}_o                per-slave qualifiers, one bit per slave
//   slave_dat_i                         packed read data, slave k at [DW*k +: DW]
//   slave_{ack,err}_i                   per-slave responses
module intercon_wb_decoder #(
    parameter int WB_DATA_WIDTH      = 32,
    parameter int WB_ADDR_WIDTH      = 32,
    parameter int WB_SEL_WIDTH       = 4,
    parameter int WB_NUM_SLAVES      = 8,
    parameter int WB_NUM_SLAVES_BITS = 3,
    parameter int SLAVE_ADDRESS_BITS = 20,
    parameter int TIMEOUT_CYCLES     = 255,
    parameter int TIMEOUT_BITS       = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [WB_DATA_WIDTH-1:0]               master_dat_i,
    input  logic                                   master_we_i,
    input  logic [WB_SEL_WIDTH-1:0]                master_sel_i,
    input  logic [WB_ADDR_WIDTH-1:0]               master_adr_i,
    input  logic                                   master_cyc_i,
    input  logic                                   master_stb_i,
    output logic [WB_DATA_WIDTH-1:0]               master_dat_o,
    output logic                                   master_ack_o,
    output logic                                   master_err_o,
    output logic [WB_DATA_WIDTH-1:0]               slave_dat_o,
    output logic [WB_NUM_SLAVES-1:0]               slave_we_o,
    output logic [WB_SEL_WIDTH-1:0]                slave_sel_o,
    output logic [WB_ADDR_WIDTH-1:0]               slave_adr_o,
    output logic [WB_NUM_SLAVES-1:0]               slave_cyc_o,
    output logic [WB_NUM_SLAVES-1:0]               slave_stb_o,
    input  logic [WB_DATA_WIDTH*WB_NUM_SLAVES-1:0] slave_dat_i,
    input  logic [WB_NUM_SLAVES-1:0]               slave_ack_i,
    input  logic [WB_NUM_SLAVES-1:0]               slave_err_i
);
    localparam int DW = WB_DATA_WIDTH;
    localparam int N  = WB_NUM_SLAVES;
    localparam int NB = WB_NUM_SLAVES_BITS;
    localparam int TB = TIMEOUT_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t        state;
    logic [NB-1:0] idx;
    logic [TB-1:0] cnt;

    logic [N-1:0][DW-1:0] rd;
    logic [N-1:0]         onehot;
    logic [NB-1:0]        field;
    logic                 mapped;
    logic                 sel_ack;
    logic                 sel_err;
    logic                 last;
    logic [DW-1:0]        sel_dat;

    assign slave_dat_o = master_dat_i;
    assign slave_sel_o = master_sel_i;
    assign slave_adr_o = master_adr_i;

    assign rd     = slave_dat_i;
    assign field  = master_adr_i[SLAVE_ADDRESS_BITS +: NB];
    // One extra bit so the compare also works when N == 2**NB.
    assign mapped = ({1'b0, field} < (NB+1)'(N));
    assign last   = (cnt == TB'(TIMEOUT_CYCLES - 1));

    // The one-hot decode doubles as the response select. This avoids indexing
    // with an index that may be wider than needed.
    for (genvar k = 0; k < N; k++) begin : g_onehot
        assign onehot[k] = (idx == NB'(k));
    end

    assign sel_ack = |(slave_ack_i & onehot);
    assign sel_err = |(slave_err_i & onehot);

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < N; k++)
            sel_dat = sel_dat | (rd[k] & {DW{onehot[k]}});
    end

    // The outputs depend only on the registered state and the live inputs.
    // An async reset clears the state, so the strobes drop at once.
    always_comb begin
        slave_cyc_o  = '0;
        slave_stb_o  = '0;
        slave_we_o   = '0;
        master_ack_o = 1'b0;
        master_err_o = 1'b0;
        master_dat_o = '0;
        case (state)
            BUSY: begin
                // When cyc drops the transfer is aborted, so nothing is
                // driven in either direction.
                if (master_cyc_i) begin
                    slave_cyc_o  = onehot;
                    slave_stb_o  = onehot & {N{master_stb_i}};
                    slave_we_o   = onehot & {N{master_we_i}};
                    master_ack_o = sel_ack & ~sel_err;
                    // A timeout only fires when the slave gave no answer
                    // this cycle.
                    master_err_o = sel_err | (last & ~sel_ack);
                    if (sel_ack & ~sel_err)
                        master_dat_o = sel_dat;
                end
            end
            ERR:     master_err_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (master_cyc_i && master_stb_i) begin
                        idx <= field;
                        if (mapped) begin
                            state <= BUSY;
                            cnt   <= '0;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    if (!master_cyc_i || sel_ack || sel_err || last)
                        state <= IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intercon_wb_decoder.sv
// tb_intercon_wb_decoder
//   Checks the interconnect every cycle against a transaction-level reference.
//   The index field is 4 bits wide and there are 8 slaves, so indices 8..15
//   are unmapped. The DUT runs directed scenarios, then random traffic.
module tb_intercon_wb_decoder;
    localparam int N  = 8;
    localparam int NB = 4;
    localparam int T  = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      mdat = '0;
    logic             mwe = 1'b0;
    logic [3:0]       msel = '0;
    logic [31:0]      madr = '0;
    logic             mcyc = 1'b0;
    logic             mstb = 1'b0;
    logic [31:0]      rdat;
    logic             ack;
    logic             err;
    logic [31:0]      sdat_o;
    logic [N-1:0]     swe;
    logic [3:0]       ssel;
    logic [31:0]      sadr;
    logic [N-1:0]     scyc;
    logic [N-1:0]     sstb;
    logic [N-1:0][31:0] sdat = '0;
    logic [N-1:0]     sack = '0;
    logic [N-1:0]     serr = '0;

    int total = 0;
    int bad = 0;

    // Reference: current target slave (-1 if none), cycles spent on it,
    // and whether an unmapped-address error is owed to the master.
    int tgt = -1;
    int age = 0;
    bit perr = 1'b0;

    intercon_wb_decoder #(
        .WB_NUM_SLAVES(N), .WB_NUM_SLAVES_BITS(NB), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .master_dat_i(mdat), .master_we_i(mwe), .master_sel_i(msel),
        .master_adr_i(madr), .master_cyc_i(mcyc), .master_stb_i(mstb),
        .master_dat_o(rdat), .master_ack_o(ack), .master_err_o(err),
        .slave_dat_o(sdat_o), .slave_we_o(swe), .slave_sel_o(ssel),
        .slave_adr_o(sadr), .slave_cyc_o(scyc), .slave_stb_o(sstb),
        .slave_dat_i(sdat), .slave_ack_i(sack), .slave_err_i(serr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] ecyc, estb, ewe;
        logic         eack, eerr;
        logic [31:0]  edat;
        ecyc = '0; estb = '0; ewe = '0; eack = 1'b0; eerr = 1'b0; edat = '0;
        if (perr) begin
            eerr = 1'b1;
        end else if (tgt >= 0 && mcyc) begin
            ecyc = N'(1 << tgt);
            estb = mstb ? ecyc : '0;
            ewe  = mwe ? ecyc : '0;
            eack = sack[tgt] && !serr[tgt];
            eerr = serr[tgt] || (age == T - 1 && !sack[tgt]);
            edat = eack ? sdat[tgt] : 32'h0;
        end
        chk("slave_cyc", 64'(scyc), 64'(ecyc));
        chk("slave_stb", 64'(sstb), 64'(estb));
        chk("slave_we", 64'(swe), 64'(ewe));
        chk("ack", 64'(ack), 64'(eack));
        chk("err", 64'(err), 64'(eerr));
        chk("rdata", 64'(rdat), 64'(edat));
        chk("bcast", {sadr, sdat_o ^ {28'h0, ssel}}, {madr, mdat ^ {28'h0, msel}});
    endtask

    task automatic model_update();
        int f;
        if (perr) begin
            perr = 1'b0;
        end else if (tgt >= 0) begin
            if (!mcyc || sack[tgt] || serr[tgt] || age == T - 1) tgt = -1;
            else age++;
        end else if (mcyc && mstb) begin
            f = int'((madr >> 20) & 32'hF);
            if (f < N) begin
                tgt = f;
                age = 0;
            end else begin
                perr = 1'b1;
            end
        end
    endtask

    // Inputs are set 1 time unit after a rising edge and checked on the
    // falling edge. The reference advances on the next rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_update();
            #1;
        end
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d);
        madr = a; mwe = w; mdat = d; msel = 4'hF; mcyc = 1'b1; mstb = 1'b1;
    endtask

    task automatic release_bus();
        mcyc = 1'b0; mstb = 1'b0; sack = '0; serr = '0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) sdat[k] = 32'hFFFF_FFFF;
        #3;
        chk("rst_cyc", 64'(scyc), 64'h0);
        chk("rst_resp", {62'h0, ack, err}, 64'h0);
        chk("rst_rdata", 64'(rdat), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2);

        // Write to slave 2, which acks three cycles after the strobe.
        req(32'h0020_0010, 1'b1, 32'h1234_5678);
        step(4);
        sack[2] = 1'b1;
        step(1);
        release_bus();
        step(2);

        // Read from slave 7. The other slaves put all-ones on their data.
        sdat[7] = 32'hDEAD_BEEF;
        req(32'h0070_0000, 1'b0, 32'h0);
        step(2);
        sack[7] = 1'b1;
        sack[0] = 1'b1;   // a stale ack from a slave that was not addressed
        step(1);
        release_bus();
        step(2);

        // Index 10 is beyond the 8 slaves, so the DUT returns an error.
        req(32'h00A0_0000, 1'b0, 32'h0);
        step(1);
        release_bus();
        step(3);

        // Slave 1 never answers and the transfer times out.
        req(32'h0010_0000, 1'b0, 32'h0);
        step(T + 3);
        release_bus();
        step(2);
        // Slave 1 acks on the cycle just before the timeout.
        req(32'h0010_0000, 1'b0, 32'h0);
        step(T - 1);
        sack[1] = 1'b1;
        step(1);
        release_bus();
        step(2);

        // Slave 3 asserts ack and err together.
        req(32'h0030_0000, 1'b0, 32'h0);
        step(2);
        sack[3] = 1'b1; serr[3] = 1'b1;
        step(1);
        release_bus();
        step(2);
        // The master drops cyc in the middle of a transfer.
        req(32'h0030_0000, 1'b1, 32'h5);
        step(3);
        mcyc = 1'b0; mstb = 1'b0;
        step(3);

        // Reset is asserted while a transfer is in progress.
        req(32'h0050_0000, 1'b1, 32'h77);
        step(3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", 64'({scyc, sstb, swe}), 64'h0);
        chk("rst_mid_resp", {62'h0, ack, err}, 64'h0);
        release_bus();
        tgt = -1; perr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);

        // Back-to-back transfers with stb held high and every slave acking.
        req(32'h0040_0000, 1'b0, 32'h0);
        sack = '1;
        step(8);
        release_bus();
        step(2);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                madr = {8'h0, 4'($urandom_range(0, 11)), 20'($urandom)};
            mwe  = 1'($urandom);
            msel = 4'($urandom);
            mdat = $urandom;
            mcyc = ($urandom_range(0, 15) != 0);
            mstb = mcyc && ($urandom_range(0, 3) != 0);
            sack = N'($urandom & $urandom);
            serr = N'($urandom & $urandom & $urandom & $urandom);
            for (int k = 0; k < N; k++) sdat[k] = $urandom;
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
